// File: rtl/grid_router_rx_lock_ctrl_pkg.sv
// Shared definitions for the receive-clock lock controller: per-channel state
// encoding and the retry counter field width.
package grid_router_rx_lock_ctrl_pkg;

  typedef enum logic [2:0] {
    StRst    = 3'd0,
    StWait   = 3'd1,
    StClr    = 3'd2,
    StSettle = 3'd3,
    StRun    = 3'd4,
    StFail   = 3'd5
  } state_e;

  localparam int unsigned RetryW = 4;

endpackage

// File: rtl/grid_router_rx_lock_chan.sv
// One receive-clock channel: synchronises LOCKED, sequences MMCM reset, BUFR clear
// and settle time, and counts lock timeouts up to a failure limit.
module grid_router_rx_lock_chan
  import grid_router_rx_lock_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              locked_i,
  input  logic              rearm_i,
  output logic              mmcm_rst_o,
  output logic              bufr_clr_o,
  output logic              ready_o,
  output logic              fail_o,
  output logic [RetryW-1:0] retry_cnt_o
);

  localparam int unsigned MaxRs  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MaxCyc = (LOCK_TIMEOUT > MaxRs) ? LOCK_TIMEOUT : MaxRs;
  localparam int unsigned CntW   = $clog2(MaxCyc);

  logic              sync1_q, lk_s_q;
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d, retry_inc;
  logic              mmcm_rst_q, bufr_clr_q, ready_q, fail_q;

  assign retry_inc = (retry_q == {RetryW{1'b1}}) ? retry_q : retry_q + RetryW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (rearm_i) begin
      state_d = StRst;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        StRst: begin
          if (cnt_q == CntW'(RST_CYCLES - 1)) begin
            state_d = StWait;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StWait: begin
          if (lk_s_q) begin
            state_d = StClr;
            cnt_d   = '0;
          end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (32'(retry_inc) == MAX_RETRY) ? StFail : StRst;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StClr: begin
          cnt_d   = '0;
          state_d = lk_s_q ? StSettle : StRst;
        end
        StSettle: begin
          if (!lk_s_q) begin
            state_d = StRst;
            cnt_d   = '0;
          end else if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
            state_d = StRun;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRun: begin
          if (!lk_s_q) begin
            state_d = StRst;
            cnt_d   = '0;
          end
        end
        StFail: ;
        default: begin
          state_d = StRst;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      lk_s_q     <= 1'b0;
      state_q    <= StRst;
      cnt_q      <= '0;
      retry_q    <= '0;
      mmcm_rst_q <= 1'b1;
      bufr_clr_q <= 1'b0;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      sync1_q    <= locked_i;
      lk_s_q     <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      mmcm_rst_q <= (state_d == StRst) || (state_d == StFail);
      bufr_clr_q <= (state_d == StClr);
      ready_q    <= (state_d == StRun);
      fail_q     <= (state_d == StFail);
    end
  end

  assign mmcm_rst_o  = mmcm_rst_q;
  assign bufr_clr_o  = bufr_clr_q;
  assign ready_o     = ready_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: rtl/grid_router_rx_lock_ctrl.sv
// Multi-channel receive-clock lock controller: NCH independent channel sequencers
// plus a registered all-channels-ready flag.
module grid_router_rx_lock_ctrl
  import grid_router_rx_lock_ctrl_pkg::*;
#(
  parameter int unsigned NCH           = 4,
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic [NCH-1:0]        locked,
  input  logic [NCH-1:0]        rearm,
  output logic [NCH-1:0]        mmcm_rst,
  output logic [NCH-1:0]        bufr_clr,
  output logic [NCH-1:0]        ready,
  output logic [NCH-1:0]        fail,
  output logic [NCH*RetryW-1:0] retry_cnt,
  output logic                  all_ready
);

  logic all_ready_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    grid_router_rx_lock_chan #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .MAX_RETRY    (MAX_RETRY)
    ) u_chan (
      .clk_i      (refclk),
      .rst_i      (rst),
      .locked_i   (locked[i]),
      .rearm_i    (rearm[i]),
      .mmcm_rst_o (mmcm_rst[i]),
      .bufr_clr_o (bufr_clr[i]),
      .ready_o    (ready[i]),
      .fail_o     (fail[i]),
      .retry_cnt_o(retry_cnt[RetryW*i +: RetryW])
    );
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      all_ready_q <= 1'b0;
    end else begin
      all_ready_q <= &ready;
    end
  end

  assign all_ready = all_ready_q;

endmodule

// File: tb/tb_grid_router_rx_lock_ctrl.sv
// Scoreboard bench: directed scenarios then random locked/rearm/rst traffic,
// compared every cycle against a countdown-based behavioural model.
module tb_grid_router_rx_lock_ctrl;

  localparam int NCH = 2;
  localparam int RC  = 3;
  localparam int LT  = 20;
  localparam int SC  = 4;
  localparam int MR  = 2;

  localparam int PhRst = 0, PhWait = 1, PhClr = 2, PhSettle = 3, PhRun = 4, PhFail = 5;

  typedef struct packed {
    logic [1:0] mmcm;
    logic [1:0] bufr;
    logic [1:0] rdy;
    logic [1:0] fl;
    logic [7:0] rc;
    logic       allr;
  } exp_t;

  logic           refclk = 1'b0;
  logic           rst;
  logic [NCH-1:0] locked, rearm;
  logic [NCH-1:0] mmcm_rst, bufr_clr, ready, fail;
  logic [NCH*4-1:0] retry_cnt;
  logic           all_ready;

  grid_router_rx_lock_ctrl #(
    .NCH          (NCH),
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (LT),
    .SETTLE_CYCLES(SC),
    .MAX_RETRY    (MR)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .locked   (locked),
    .rearm    (rearm),
    .mmcm_rst (mmcm_rst),
    .bufr_clr (bufr_clr),
    .ready    (ready),
    .fail     (fail),
    .retry_cnt(retry_cnt),
    .all_ready(all_ready)
  );

  always #5 refclk = ~refclk;

  exp_t sb_q[$];
  exp_t cur;
  int   m_ph[NCH], m_left[NCH], m_rc[NCH];
  bit   m_s1[NCH], m_s2[NCH];
  int   n_checks = 0, n_pass = 0, cyc = 0;
  bit   drv_done = 1'b0;

  // Reference: each channel is a phase with a remaining-cycles countdown.
  task automatic model_step(input logic r, input logic [NCH-1:0] lk, input logic [NCH-1:0] ra);
    exp_t e;
    bit   l;
    e = '0;
    e.allr = r ? 1'b0 : &cur.rdy;
    for (int ch = 0; ch < NCH; ch++) begin
      if (r) begin
        m_ph[ch] = PhRst; m_left[ch] = RC; m_rc[ch] = 0; m_s1[ch] = 0; m_s2[ch] = 0;
      end else begin
        l = m_s2[ch];
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = lk[ch];
        if (ra[ch]) begin
          m_ph[ch] = PhRst; m_left[ch] = RC; m_rc[ch] = 0;
        end else begin
          case (m_ph[ch])
            PhRst: begin
              m_left[ch]--;
              if (m_left[ch] == 0) begin m_ph[ch] = PhWait; m_left[ch] = LT; end
            end
            PhWait: begin
              if (l) m_ph[ch] = PhClr;
              else begin
                m_left[ch]--;
                if (m_left[ch] == 0) begin
                  m_rc[ch] = (m_rc[ch] >= 15) ? 15 : m_rc[ch] + 1;
                  m_ph[ch] = (m_rc[ch] == MR) ? PhFail : PhRst;
                  m_left[ch] = RC;
                end
              end
            end
            PhClr: begin
              if (l) begin m_ph[ch] = PhSettle; m_left[ch] = SC; end
              else begin m_ph[ch] = PhRst; m_left[ch] = RC; end
            end
            PhSettle: begin
              if (!l) begin m_ph[ch] = PhRst; m_left[ch] = RC; end
              else begin
                m_left[ch]--;
                if (m_left[ch] == 0) begin m_ph[ch] = PhRun; m_rc[ch] = 0; end
              end
            end
            PhRun: if (!l) begin m_ph[ch] = PhRst; m_left[ch] = RC; end
            default: ;
          endcase
        end
      end
      e.mmcm[ch] = (m_ph[ch] == PhRst) || (m_ph[ch] == PhFail);
      e.bufr[ch] = (m_ph[ch] == PhClr);
      e.rdy[ch]  = (m_ph[ch] == PhRun);
      e.fl[ch]   = (m_ph[ch] == PhFail);
      e.rc[4*ch +: 4] = 4'(m_rc[ch]);
    end
    cur = e;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [NCH-1:0] lk, input logic [NCH-1:0] ra);
    @(negedge refclk);
    rst = r; locked = lk; rearm = ra;
    model_step(r, lk, ra);
  endtask

  task automatic hold(input int n, input logic [NCH-1:0] lk);
    for (int i = 0; i < n; i++) drive(1'b0, lk, 2'b00);
  endtask

  // Driver
  initial begin
    logic [NCH-1:0] lk;
    rst = 1'b1; locked = '0; rearm = '0;
    cur = '0;
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 2'b00);
    hold(10, 2'b00);
    hold(70, 2'b01);                        // ch0 locks, ch1 times out into fail
    drive(1'b0, 2'b00, 2'b00);              // one-cycle loss on ch0
    hold(30, 2'b01);
    drive(1'b0, 2'b11, 2'b10);              // rearm ch1 with lock present
    hold(30, 2'b11);
    drive(1'b1, 2'b11, 2'b00);              // reset with both running
    hold(30, 2'b11);
    hold(2, 2'b10);
    drive(1'b0, 2'b10, 2'b01);              // rearm coincides with lock loss seen by FSM
    hold(30, 2'b11);
    lk = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      logic [NCH-1:0] ra;
      for (int ch = 0; ch < NCH; ch++) begin
        if (lk[ch]) begin
          if ($urandom_range(59) == 0) lk[ch] = 1'b0;
        end else if ($urandom_range((i < 1500) ? 14 : 30) == 0) lk[ch] = 1'b1;
        ra[ch] = ($urandom_range(149) == 0);
      end
      drive(($urandom_range(499) == 0), lk, ra);
    end
    drv_done = 1'b1;
  end

  // Monitor
  initial begin
    exp_t e, a;
    forever begin
      @(posedge refclk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = '{mmcm: mmcm_rst, bufr: bufr_clr, rdy: ready, fl: fail, rc: retry_cnt,
              allr: all_ready};
        n_checks++;
        if (a === e) n_pass++;
        else
          $display("FAIL outputs cycle %0d: got mmcm_rst=%b bufr_clr=%b ready=%b fail=%b retry_cnt=%h all_ready=%b, want mmcm_rst=%b bufr_clr=%b ready=%b fail=%b retry_cnt=%h all_ready=%b",
                   cyc, a.mmcm, a.bufr, a.rdy, a.fl, a.rc, a.allr,
                   e.mmcm, e.bufr, e.rdy, e.fl, e.rc, e.allr);
      end
    end
  end

  initial begin
    wait (drv_done);
    repeat (3) @(posedge refclk);
    #2;
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected entries left, want 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
